// File: rtl/onchip_mem_rr_arbiter_if.sv
// Requester and memory-port bundle for the on-chip memory arbiter.
// The arbiter takes the slave view; requesters and memory take master.
interface onchip_mem_rr_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16,
  parameter int BE_W   = DATA_W / 8
);
  logic              r0_req;
  logic              r0_write;
  logic [ADDR_W-1:0] r0_address;
  logic [DATA_W-1:0] r0_writedata;
  logic [BE_W-1:0]   r0_byteenable;
  logic              r0_ack;
  logic [DATA_W-1:0] r0_readdata;
  logic              r1_req;
  logic              r1_write;
  logic [ADDR_W-1:0] r1_address;
  logic [DATA_W-1:0] r1_writedata;
  logic [BE_W-1:0]   r1_byteenable;
  logic              r1_ack;
  logic [DATA_W-1:0] r1_readdata;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_clken;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic [BE_W-1:0]   mem_byteenable;
  logic [DATA_W-1:0] mem_readdata;
  logic              busy;

  modport slave (
    input  r0_req, r0_write, r0_address,
    input  r0_writedata, r0_byteenable,
    output r0_ack, r0_readdata,
    input  r1_req, r1_write, r1_address,
    input  r1_writedata, r1_byteenable,
    output r1_ack, r1_readdata,
    output mem_address, mem_clken,
    output mem_chipselect, mem_write,
    output mem_writedata, mem_byteenable,
    input  mem_readdata,
    output busy
  );

  modport master (
    output r0_req, r0_write, r0_address,
    output r0_writedata, r0_byteenable,
    input  r0_ack, r0_readdata,
    output r1_req, r1_write, r1_address,
    output r1_writedata, r1_byteenable,
    input  r1_ack, r1_readdata,
    input  mem_address, mem_clken,
    input  mem_chipselect, mem_write,
    input  mem_writedata, mem_byteenable,
    output mem_readdata,
    input  busy
  );
endinterface

// File: rtl/onchip_mem_rr_arbiter.sv
// Two-requester round-robin sequencer for the single-port on-chip memory.
// One transaction at a time: IDLE -> ISSUE -> [READ] -> DONE -> IDLE.
module onchip_mem_rr_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16,
  parameter int BE_W   = DATA_W / 8
) (
  input logic clk_clk,
  input logic reset_reset_n,
  onchip_mem_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    READ,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic grant_q, grant_d;
  logic last_q, last_d;
  logic wr_q, wr_d;
  logic cs_q, cs_d;
  logic clken_q, clken_d;
  logic mwr_q, mwr_d;
  logic ack0_q, ack0_d;
  logic ack1_q, ack1_d;
  logic busy_q, busy_d;
  logic sel;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] rd0_q, rd0_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    cs_d    = 1'b0;
    clken_d = 1'b0;
    mwr_d   = 1'b0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    sel     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.r0_req || bus.r1_req) begin
          // on a tie the requester not served last wins
          sel = (bus.r0_req && bus.r1_req) ?
                ~last_q : bus.r1_req;
          grant_d = sel;
          wr_d    = sel ? bus.r1_write
                        : bus.r0_write;
          addr_d  = sel ? bus.r1_address
                        : bus.r0_address;
          wdata_d = sel ? bus.r1_writedata
                        : bus.r0_writedata;
          be_d    = sel ? bus.r1_byteenable
                        : bus.r0_byteenable;
          cs_d    = 1'b1;
          clken_d = 1'b1;
          mwr_d   = wr_d;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (wr_q) begin
          ack0_d  = ~grant_q;
          ack1_d  = grant_q;
          state_d = DONE;
        end else begin
          clken_d = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        if (grant_q) rd1_d = bus.mem_readdata;
        else         rd0_d = bus.mem_readdata;
        ack0_d  = ~grant_q;
        ack1_d  = grant_q;
        state_d = DONE;
      end
      DONE: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      cs_q    <= 1'b0;
      clken_q <= 1'b0;
      mwr_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      cs_q    <= cs_d;
      clken_q <= clken_d;
      mwr_q   <= mwr_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.r0_ack         = ack0_q;
  assign bus.r0_readdata    = rd0_q;
  assign bus.r1_ack         = ack1_q;
  assign bus.r1_readdata    = rd1_q;
  assign bus.mem_address    = addr_q;
  assign bus.mem_clken      = clken_q;
  assign bus.mem_chipselect = cs_q;
  assign bus.mem_write      = mwr_q;
  assign bus.mem_writedata  = wdata_q;
  assign bus.mem_byteenable = be_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_onchip_mem_rr_arbiter.sv
// Randomised bench for onchip_mem_rr_arbiter with a 1-cycle memory
// model and a transaction-level reference of arbitration and contents.
module tb_onchip_mem_rr_arbiter;

  localparam int AW = 11;
  localparam int DW = 16;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [1:0]    be;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  onchip_mem_rr_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  onchip_mem_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (bus)
  );

  logic [DW-1:0] mem [2048];
  logic [DW-1:0] ref_mem [2048];
  logic [DW-1:0] exp_rd [2];
  bit   model_last;
  int   total = 0;
  int   bad = 0;
  txn_t q0[$];
  txn_t q1[$];

  always @(posedge clk) begin
    if (bus.mem_clken && bus.mem_chipselect) begin
      if (bus.mem_write) begin
        if (bus.mem_byteenable[0])
          mem[bus.mem_address][7:0] <= bus.mem_writedata[7:0];
        if (bus.mem_byteenable[1])
          mem[bus.mem_address][15:8] <= bus.mem_writedata[15:8];
      end else begin
        bus.mem_readdata <= mem[bus.mem_address];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] merge(
    logic [DW-1:0] old, logic [DW-1:0] d, logic [1:0] be);
    logic [DW-1:0] r;
    r = old;
    if (be[0]) r[7:0] = d[7:0];
    if (be[1]) r[15:8] = d[15:8];
    return r;
  endfunction

  task automatic drive(int n, txn_t t, logic req);
    if (n == 0) begin
      bus.r0_req = req; bus.r0_write = t.wr;
      bus.r0_address = t.a; bus.r0_writedata = t.d;
      bus.r0_byteenable = t.be;
    end else begin
      bus.r1_req = req; bus.r1_write = t.wr;
      bus.r1_address = t.a; bus.r1_writedata = t.d;
      bus.r1_byteenable = t.be;
    end
  endtask

  task automatic idle_all();
    txn_t z;
    z = '0;
    drive(0, z, 1'b0);
    drive(1, z, 1'b0);
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.wr = 1'($urandom_range(0, 1));
    t.a  = ($urandom_range(0, 3) == 0) ? 11'h7FF
                                       : 11'($urandom_range(0, 7));
    t.d  = 16'($urandom);
    t.be = 2'($urandom_range(0, 3));
    return t;
  endfunction

  function automatic bit pick();
    if (q0.size() > 0 && q1.size() > 0) return ~model_last;
    return q1.size() > 0;
  endfunction

  task automatic do_reset();
    idle_all();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_last = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  task automatic run_queues(string tag);
    int cnt;
    bit w;
    txn_t h;
    txn_t z;
    z = '0;
    if (q0.size() == 0 && q1.size() == 0) return;
    drive(0, q0.size() > 0 ? q0[0] : z, q0.size() > 0);
    drive(1, q1.size() > 0 ? q1[0] : z, q1.size() > 0);
    w = pick();
    cnt = 0;
    while (q0.size() > 0 || q1.size() > 0) begin
      step();
      cnt++;
      if (bus.r0_ack || bus.r1_ack) begin
        h = w ? q1[0] : q0[0];
        total++;
        if ((bus.r0_ack && bus.r1_ack) || bus.r1_ack != w) begin
          bad++;
          $display("FAIL %s grant: r0_ack=%0b r1_ack=%0b want r%0d",
                   tag, bus.r0_ack, bus.r1_ack, w);
          idle_all(); q0.delete(); q1.delete(); step();
          return;
        end
        total++;
        if (cnt != (h.wr ? 2 : 3)) begin
          bad++;
          $display("FAIL %s latency: got %0d want %0d",
                   tag, cnt, h.wr ? 2 : 3);
        end
        if (h.wr) ref_mem[h.a] = merge(ref_mem[h.a], h.d, h.be);
        else exp_rd[w] = ref_mem[h.a];
        total++;
        if (bus.r0_readdata !== exp_rd[0] ||
            bus.r1_readdata !== exp_rd[1]) begin
          bad++;
          $display("FAIL %s readdata: got %h/%h want %h/%h", tag,
                   bus.r0_readdata, bus.r1_readdata,
                   exp_rd[0], exp_rd[1]);
        end
        model_last = w;
        if (w) void'(q1.pop_front());
        else   void'(q0.pop_front());
        if (w) drive(1, q1.size() > 0 ? q1[0] : z, q1.size() > 0);
        else   drive(0, q0.size() > 0 ? q0[0] : z, q0.size() > 0);
        if (q0.size() > 0 || q1.size() > 0) w = pick();
        cnt = -1;
      end else if (cnt > 3) begin
        bad++;
        total++;
        $display("FAIL %s timeout: no ack after %0d cycles", tag, cnt);
        idle_all(); q0.delete(); q1.delete(); step();
        return;
      end
    end
    step();
    total++;
    if (bus.busy !== 1'b0 || bus.r0_ack || bus.r1_ack) begin
      bad++;
      $display("FAIL %s idle_after: busy=%0b acks=%0b%0b want 0",
               tag, bus.busy, bus.r0_ack, bus.r1_ack);
    end
  endtask

  task automatic test_reset();
    logic [99:0] outs;
    idle_all();
    rst_n = 1'b0;
    step();
    outs = {bus.r0_ack, bus.r1_ack, bus.r0_readdata, bus.r1_readdata,
            bus.mem_address, bus.mem_clken, bus.mem_chipselect,
            bus.mem_write, bus.mem_writedata, bus.mem_byteenable,
            bus.busy};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL reset_outs: got %h want 0", outs);
    end
    bus.r0_req = 1'b1;
    step();
    total++;
    if (bus.busy !== 1'b0 || bus.mem_chipselect !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: busy=%0b cs=%0b want 0",
               bus.busy, bus.mem_chipselect);
    end
    bus.r0_req = 1'b0;
    rst_n = 1'b1;
    model_last = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (bus.busy || bus.mem_chipselect || bus.r0_ack || bus.r1_ack) begin
        bad++;
        $display("FAIL idle_noreq: busy=%0b cs=%0b want 0",
                 bus.busy, bus.mem_chipselect);
      end
    end
  endtask

  task automatic test_write();
    txn_t t;
    t = '{wr: 1'b1, a: 11'h005, d: 16'hBEEF, be: 2'b11};
    drive(0, t, 1'b1);
    step();
    total++;
    if (!(bus.mem_chipselect && bus.mem_clken && bus.mem_write &&
          bus.mem_address == 11'h005 && bus.mem_writedata == 16'hBEEF &&
          bus.mem_byteenable == 2'b11 && !bus.r0_ack)) begin
      bad++;
      $display("FAIL write_issue: cs=%0b wr=%0b a=%h d=%h be=%b want 1 1 005 beef 11",
               bus.mem_chipselect, bus.mem_write, bus.mem_address,
               bus.mem_writedata, bus.mem_byteenable);
    end
    step();
    total++;
    if (bus.r0_ack !== 1'b1 || bus.r1_ack !== 1'b0 ||
        bus.mem_chipselect !== 1'b0 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL write_ack: ack0=%0b ack1=%0b cs=%0b want 1 0 0",
               bus.r0_ack, bus.r1_ack, bus.mem_chipselect);
    end
    drive(0, t, 1'b0);
    ref_mem[5] = merge(ref_mem[5], t.d, t.be);
    model_last = 1'b0;
    step();
    total++;
    if (bus.r0_ack !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL write_idle: ack0=%0b busy=%0b want 0",
               bus.r0_ack, bus.busy);
    end
  endtask

  task automatic test_read();
    txn_t t;
    t = '{wr: 1'b0, a: 11'h005, d: 16'h0000, be: 2'b00};
    drive(0, t, 1'b1);
    step();
    total++;
    if (bus.mem_chipselect !== 1'b1 || bus.mem_write !== 1'b0) begin
      bad++;
      $display("FAIL read_issue: cs=%0b wr=%0b want 1 0",
               bus.mem_chipselect, bus.mem_write);
    end
    step();
    total++;
    if (bus.mem_chipselect || !bus.mem_clken || bus.r0_ack) begin
      bad++;
      $display("FAIL read_wait: cs=%0b clken=%0b ack0=%0b want 0 1 0",
               bus.mem_chipselect, bus.mem_clken, bus.r0_ack);
    end
    step();
    total++;
    if (bus.r0_ack !== 1'b1 || bus.r1_ack !== 1'b0 ||
        bus.r0_readdata !== 16'hBEEF) begin
      bad++;
      $display("FAIL read_ack: ack0=%0b ack1=%0b rd=%h want 1 0 beef",
               bus.r0_ack, bus.r1_ack, bus.r0_readdata);
    end
    drive(0, t, 1'b0);
    exp_rd[0] = ref_mem[5];
    model_last = 1'b0;
    step();
  endtask

  task automatic test_tie();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      q0.push_back('{wr: 1'b0, a: 11'h005, d: 16'h0, be: 2'b0});
      q1.push_back('{wr: 1'b0, a: 11'(i), d: 16'h0, be: 2'b0});
    end
    run_queues("tie");
  endtask

  task automatic test_be_wrap();
    q0.push_back('{wr: 1'b1, a: 11'h7FF, d: 16'hBEEF, be: 2'b11});
    q0.push_back('{wr: 1'b1, a: 11'h7FF, d: 16'h1234, be: 2'b01});
    q0.push_back('{wr: 1'b0, a: 11'h7FF, d: 16'h0, be: 2'b00});
    run_queues("be_wrap");
    total++;
    if (bus.r0_readdata !== 16'hBE34) begin
      bad++;
      $display("FAIL be_merge: got %h want be34", bus.r0_readdata);
    end
    q1.push_back('{wr: 1'b1, a: 11'h7FF, d: 16'hFFFF, be: 2'b00});
    q1.push_back('{wr: 1'b0, a: 11'h7FF, d: 16'h0, be: 2'b00});
    run_queues("be_zero");
    total++;
    if (bus.r1_readdata !== 16'hBE34) begin
      bad++;
      $display("FAIL be_zero_data: got %h want be34", bus.r1_readdata);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int n0, n1;
      n0 = $urandom_range(0, 6);
      n1 = $urandom_range(1, 6);
      for (int i = 0; i < n0; i++) q0.push_back(rand_txn());
      for (int i = 0; i < n1; i++) q1.push_back(rand_txn());
      run_queues("random");
    end
  endtask

  task automatic test_reset_mid();
    txn_t t;
    t = '{wr: 1'b0, a: 11'h005, d: 16'h0, be: 2'b00};
    drive(0, t, 1'b1);
    step();
    step();
    total++;
    if (bus.busy !== 1'b1 || bus.mem_chipselect !== 1'b0) begin
      bad++;
      $display("FAIL mid_read_state: busy=%0b cs=%0b want 1 0",
               bus.busy, bus.mem_chipselect);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.busy || bus.r0_ack || bus.mem_clken ||
        bus.r0_readdata !== '0) begin
      bad++;
      $display("FAIL mid_reset: busy=%0b ack0=%0b clken=%0b want 0",
               bus.busy, bus.r0_ack, bus.mem_clken);
    end
    idle_all();
    step();
    step();
    rst_n = 1'b1;
    model_last = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (bus.r0_ack || bus.r1_ack || bus.busy) begin
        bad++;
        $display("FAIL mid_noack: ack0=%0b ack1=%0b busy=%0b want 0",
                 bus.r0_ack, bus.r1_ack, bus.busy);
      end
    end
    q1.push_back('{wr: 1'b1, a: 11'h020, d: 16'hA5A5, be: 2'b11});
    q0.push_back('{wr: 1'b0, a: 11'h005, d: 16'h0, be: 2'b00});
    q1.push_back('{wr: 1'b0, a: 11'h020, d: 16'h0, be: 2'b00});
    run_queues("after_reset");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    bus.mem_readdata = '0;
    model_last = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_tie();
    test_be_wrap();
    test_random();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
